// File: rtl/cells_pkg.sv
// rtl/cells_pkg.sv - shared cell-library constants and write-priority encoding
package cells_pkg;

    localparam int DECAY_DEFAULT = 16;
    localparam int NIN_MIN       = 1;
    localparam int NIN_MAX       = 4;

    typedef enum logic [2:0] {
        WR_DRV0  = 3'd0,
        WR_DRV1  = 3'd1,
        WR_EN    = 3'd2,
        WR_DECAY = 3'd3,
        WR_HOLD  = 3'd4
    } wr_sel_t;

    // Pulldown beats pullup beats pass gate beats charge loss.
    function automatic wr_sel_t wr_select(input logic drv0, input logic drv1,
                                          input logic en, input logic expire);
        if (drv0)        return WR_DRV0;
        else if (drv1)   return WR_DRV1;
        else if (en)     return WR_EN;
        else if (expire) return WR_DECAY;
        else             return WR_HOLD;
    endfunction

endpackage

// File: rtl/dlatch_nor_bank_charge_timer.sv
// rtl/dlatch_nor_bank_charge_timer.sv - saturating hold counter with one-cycle expiry pulse
module charge_timer #(
    parameter int DECAY = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic write,
    input  logic valid,
    output logic expire,
    output logic decay_err
);

    localparam int CW          = (DECAY > 0) ? $clog2(DECAY + 1) : 1;
    localparam logic HAS_DECAY = (DECAY > 0);
    localparam int LAST        = (DECAY > 0) ? DECAY - 1 : 0;

    logic [CW-1:0] cnt;

    // Expiry is suppressed by any write landing on the same edge.
    always_comb begin
        expire = HAS_DECAY && valid && !write && (cnt == CW'(LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            decay_err <= 1'b0;
        end else begin
            decay_err <= expire;
            if (!HAS_DECAY || write || !valid || expire) begin
                cnt <= '0;
            end else if (cnt < CW'(DECAY)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dlatch_nor_bank.sv
// rtl/dlatch_nor_bank.sv - bank of NOR-fed dynamic latches with drivers and charge decay
module dlatch_nor_bank
    import cells_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NIN   = 2,
    parameter int DECAY = DECAY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NIN*WIDTH-1:0]  a,
    input  logic                  drv0,
    input  logic                  drv1,
    output logic [WIDTH-1:0]      y,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic                  decay_err,
    output logic                  contention
);

    if (NIN < NIN_MIN || NIN > NIN_MAX || WIDTH < 1) begin : g_bad_param
        $error("dlatch_nor_bank: NIN must be 1..4 and WIDTH >= 1");
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_nor
        assign y[b] = ~|a[b*NIN +: NIN];
    end

    logic    write;
    logic    expire;
    wr_sel_t sel;

    assign write = drv0 | drv1 | en;
    assign sel   = wr_select(drv0, drv1, en, expire);

    // One timer for the whole bank: every bit shares the same enables.
    charge_timer #(
        .DECAY (DECAY)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .valid     (q_valid),
        .expire    (expire),
        .decay_err (decay_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            q_valid    <= 1'b0;
            contention <= 1'b0;
        end else begin
            contention <= drv0 & drv1;
            case (sel)
                WR_DRV0: begin
                    q       <= '0;
                    q_valid <= 1'b1;
                end
                WR_DRV1: begin
                    q       <= '1;
                    q_valid <= 1'b1;
                end
                WR_EN: begin
                    q       <= y;
                    q_valid <= 1'b1;
                end
                WR_DECAY: begin
                    q       <= '0;
                    q_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dlatch_nor_bank.sv
// tb/tb_dlatch_nor_bank.sv - self-checking bench for dlatch_nor_bank
module tb_dlatch_nor_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        drv0 = 1'b0;
    logic        drv1 = 1'b0;
    logic [11:0] a = 12'h000;

    logic [3:0]  y, q, y_nd, q_nd;
    logic        q_valid, decay_err, contention;
    logic        q_valid_nd, decay_err_nd, contention_nd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dlatch_nor_bank #(.WIDTH(4), .NIN(3), .DECAY(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .drv0       (drv0),
        .drv1       (drv1),
        .y          (y),
        .q          (q),
        .q_valid    (q_valid),
        .decay_err  (decay_err),
        .contention (contention)
    );

    dlatch_nor_bank #(.WIDTH(4), .NIN(3), .DECAY(0)) dut_nd (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .drv0       (drv0),
        .drv1       (drv1),
        .y          (y_nd),
        .q          (q_nd),
        .q_valid    (q_valid_nd),
        .decay_err  (decay_err_nd),
        .contention (contention_nd)
    );

    typedef struct {
        logic [11:0] a;
        logic        en;
        logic        d0;
        logic        d1;
        logic [3:0]  ey;
        logic [3:0]  eq;
        logic        ev;
        logic        ede;
        logic        ect;
        string       name;
    } vec_t;

    typedef struct {
        logic [3:0] eq;
        logic       ev;
        logic       ede;
        logic       ect;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        a = v.a; en = v.en; drv0 = v.d0; drv1 = v.d1;
        #1;
        chk({v.name, ".y"}, 32'(y), 32'(v.ey));
        e.eq = v.eq; e.ev = v.ev; e.ede = v.ede; e.ect = v.ect; e.name = v.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({v.name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".q"}, 32'(q), 32'(e.eq));
            chk({e.name, ".q_valid"}, 32'(q_valid), 32'(e.ev));
            chk({e.name, ".decay_err"}, 32'(decay_err), 32'(e.ede));
            chk({e.name, ".contention"}, 32'(contention), 32'(e.ect));
        end
    endtask

    function automatic vec_t mk(input logic [11:0] ia, input logic ien, input logic id0,
                                input logic id1, input logic [3:0] ey, input logic [3:0] eq,
                                input logic ev, input logic ede, input logic ect, input string n);
        vec_t v;
        v.a = ia; v.en = ien; v.d0 = id0; v.d1 = id1;
        v.ey = ey; v.eq = eq; v.ev = ev; v.ede = ede; v.ect = ect; v.name = n;
        return v;
    endfunction

    initial begin
        tbl[0] = mk(12'h000, 1, 0, 0, 4'hF, 4'hF, 1, 0, 0, "t_en_000");
        tbl[1] = mk(12'h001, 1, 0, 0, 4'hE, 4'hE, 1, 0, 0, "t_en_001");
        tbl[2] = mk(12'h249, 1, 0, 0, 4'h0, 4'h0, 1, 0, 0, "t_en_249");
        tbl[3] = mk(12'hE00, 1, 0, 0, 4'h7, 4'h7, 1, 0, 0, "t_en_e00");
        tbl[4] = mk(12'h038, 1, 0, 0, 4'hD, 4'hD, 1, 0, 0, "t_en_038");
        tbl[5] = mk(12'h000, 1, 1, 1, 4'hF, 4'h0, 1, 0, 1, "t_contend");
        tbl[6] = mk(12'h001, 0, 0, 1, 4'hE, 4'hF, 1, 0, 0, "t_drv1");
        tbl[7] = mk(12'h041, 1, 1, 0, 4'hA, 4'h0, 1, 0, 0, "t_drv0_over_en");
        tbl[8] = mk(12'h041, 1, 0, 1, 4'hA, 4'hF, 1, 0, 0, "t_drv1_over_en");
        tbl[9] = mk(12'h041, 1, 0, 0, 4'hA, 4'hA, 1, 0, 0, "t_en_041");

        // Reset state; y must stay live while rst is held
        #1;
        chk("rst.y", 32'(y), 32'hF);
        @(posedge clk); #1;
        chk("rst.q", 32'(q), 32'h0);
        chk("rst.q_valid", 32'(q_valid), 32'h0);
        chk("rst.decay_err", 32'(decay_err), 32'h0);
        chk("rst.contention", 32'(contention), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Full expiry: pulse on the 5th idle edge only
        step(mk(12'h000, 1, 0, 0, 4'hF, 4'hF, 1, 0, 0, "a_wr"));
        for (int i = 0; i < 4; i++) step(mk(12'h000, 0, 0, 0, 4'hF, 4'hF, 1, 0, 0, "a_hold"));
        step(mk(12'h000, 0, 0, 0, 4'hF, 4'h0, 0, 1, 0, "a_expire"));
        step(mk(12'h000, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, "a_after1"));
        step(mk(12'h000, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, "a_after2"));

        // Write in the expiry cycle wins and restarts the count
        step(mk(12'h001, 1, 0, 0, 4'hE, 4'hE, 1, 0, 0, "b_wr"));
        for (int i = 0; i < 4; i++) step(mk(12'h001, 0, 0, 0, 4'hE, 4'hE, 1, 0, 0, "b_hold"));
        step(mk(12'h038, 1, 0, 0, 4'hD, 4'hD, 1, 0, 0, "b_rescue"));
        for (int i = 0; i < 4; i++) step(mk(12'h038, 0, 0, 0, 4'hD, 4'hD, 1, 0, 0, "b_hold2"));
        step(mk(12'h038, 0, 0, 0, 4'hD, 4'h0, 0, 1, 0, "b_expire"));

        // Asynchronous reset between edges during a hold
        step(mk(12'h041, 1, 0, 0, 4'hA, 4'hA, 1, 0, 0, "c_wr"));
        step(mk(12'h041, 0, 0, 0, 4'hA, 4'hA, 1, 0, 0, "c_hold"));
        #2 rst = 1'b1;
        #1;
        chk("c_rst.q", 32'(q), 32'h0);
        chk("c_rst.q_valid", 32'(q_valid), 32'h0);
        chk("c_rst.y", 32'(y), 32'hA);
        #1 rst = 1'b0;
        for (int i = 0; i < 7; i++) step(mk(12'h041, 0, 0, 0, 4'hA, 4'h0, 0, 0, 0, "c_post"));

        // No-decay instance holds indefinitely
        step(mk(12'h208, 1, 0, 0, 4'h5, 4'h5, 1, 0, 0, "d_wr"));
        chk("d_wr.q_nd", 32'(q_nd), 32'h5);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            en = 1'b0;
            @(posedge clk); #1;
            if (decay_err_nd !== 1'b0) chk("d_hold.decay_err_nd", 32'(decay_err_nd), 32'h0);
        end
        chk("d_end.decay_err_nd", 32'(decay_err_nd), 32'h0);
        chk("d_end.q_nd", 32'(q_nd), 32'h5);
        chk("d_end.q_valid_nd", 32'(q_valid_nd), 32'h1);
        chk("d_end.sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
